// File: rtl/decode_queue.sv
// Decode stage with a small FIFO of decoded instructions between fetch and execute.
// Operands are captured from the register file in the same cycle the instruction is accepted.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [31:0]                  in_cmd,
  output logic [4:0]                   reg1,
  output logic [4:0]                   reg2,
  input  logic [XLEN-1:0]              reg_out1,
  input  logic [XLEN-1:0]              reg_out2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_pc,
  output logic [5:0]                   out_exec_command,
  output logic [5:0]                   out_alu_command,
  output logic [XLEN-1:0]              out_addr,
  output logic [XLEN-1:0]              out_rs,
  output logic [XLEN-1:0]              out_rt,
  output logic [4:0]                   out_sh,
  output logic [4:0]                   out_rd,
  output logic                         out_fmode,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  stall_cycles
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [5:0]      exec;
    logic [5:0]      alu;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic [4:0]      sh;
    logic [4:0]      rd;
    logic            fmode;
  } entry_t;

  entry_t          dec, head;
  entry_t          mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic            push, pop;
  logic [5:0]      op;
  logic [XLEN-1:0] simm;

  assign op   = in_cmd[31:26];
  assign simm = {{(XLEN-16){in_cmd[15]}}, in_cmd[15:0]};

  // Branches and stores read rt from the rd field position.
  assign reg1 = in_cmd[20:16];
  assign reg2 = (in_cmd[31:27] == 5'b00010 || in_cmd[31:29] == 3'b101) ?
                in_cmd[25:21] : in_cmd[15:11];

  always_comb begin
    dec       = '0;
    dec.pc    = in_pc;
    dec.exec  = op;
    dec.rd    = in_cmd[25:21];
    dec.sh    = in_cmd[10:6];
    dec.alu   = in_cmd[5:0];
    dec.rs    = reg_out1;
    dec.rt    = reg_out2;
    dec.fmode = (op == 6'b010001);
    if (op == 6'b000010 || op == 6'b000011)
      dec.addr = {{(XLEN-28){1'b0}}, in_cmd[25:0], 2'b00};
    else if (op == 6'b000100 || op == 6'b000101)
      dec.addr = {{(XLEN-18){in_cmd[15]}}, in_cmd[15:0], 2'b00};
    else if (op == 6'b001000)
      dec.rt = simm;
    else if (op[5:2] == 4'b0011)
      dec.rt = {{(XLEN-16){1'b0}}, in_cmd[15:0]};
    else if (op[5:4] == 2'b10)
      dec.addr = reg_out1 + simm;
    else if (op == 6'b110010)
      dec.addr = {{(XLEN-28){in_cmd[25]}}, in_cmd[25:0], 2'b00};
  end

  // in_ready depends only on local state, never on out_ready.
  assign in_ready  = !rst && (count != FULL) && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      wptr         <= '0;
      rptr         <= '0;
      stall_cycles <= '0;
    end else begin
      if (in_valid && !in_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (flush) begin
        count <= '0;
        wptr  <= '0;
        rptr  <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dec;
  end

  assign head = out_valid ? mem[rptr] : '0;

  assign out_pc           = head.pc;
  assign out_exec_command = head.exec;
  assign out_alu_command  = head.alu;
  assign out_addr         = head.addr;
  assign out_rs           = head.rs;
  assign out_rt           = head.rt;
  assign out_sh           = head.sh;
  assign out_rd           = head.rd;
  assign out_fmode        = head.fmode;
endmodule
